cond_exec_unit: RTL and testbench
=================================

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port StallE, input, 1 bit: execute stage held this cycle.
REQ-004 SHALL have port CondE, input, 4 bits: condition code of the instruction in execute.
REQ-005 SHALL have port FlagWE, input, 3 bits: flag-write enables; bit2 = N and Z, bit1 = C, bit0 = V.
REQ-006 SHALL have ports PCSE, RegWE, MemWE, NoWriteE, inputs, 1 bit each: ungated controls from the decode/execute buffer.
REQ-007 SHALL have port ALUFlags, input, 4 bits {N,Z,C,V}: flags produced by the ALU this cycle.
REQ-008 SHALL have ports PCSrcE, RegWriteE, MemWriteE, outputs, 1 bit each: gated controls.
REQ-009 SHALL have port CondExE, output, 1 bit: condition passed.
REQ-010 SHALL have port Flags, output, 4 bits {N,Z,C,V}: architectural flag register.
REQ-011 SHALL have port SquashCount, output, 16 bits: count of condition-failed instructions.

Function
REQ-012 CondExE SHALL be evaluated combinationally from CondE and the registered Flags.
- EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C.
- MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
- HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V.
- GT 1100: !Z&(N==V). LE 1101: Z|(N!=V). AL 1110: 1. 1111: 0.
REQ-013 PCSrcE SHALL equal PCSE & CondExE & !StallE.
REQ-014 MemWriteE SHALL equal MemWE & CondExE & !StallE.
REQ-015 RegWriteE SHALL equal RegWE & CondExE & !NoWriteE & !StallE.
REQ-016 On a clock edge with CondExE=1 and StallE=0, the flag register SHALL update per enable:
- FlagWE[2]: N and Z load from ALUFlags.
- FlagWE[1]: C loads.
- FlagWE[0]: V loads.
- Bits whose enable is low hold their value.
REQ-017 A flag update SHALL become visible to CondExE exactly one cycle later; there is no same-cycle bypass.
REQ-018 When CondExE=0, Flags SHALL hold regardless of FlagWE.
REQ-019 While StallE=1, Flags and SquashCount SHALL hold and all gated outputs SHALL be 0.
REQ-020 A bubble (all controls 0, FlagWE=0) SHALL leave all state unchanged, except under REQ-024.

Reset
REQ-021 While RESET=1, Flags SHALL be 0000 and SquashCount SHALL be 0, taking effect immediately and independent of CLK.
REQ-022 Gated outputs SHALL remain purely combinational during reset, evaluated against Flags=0000 (so EQ fails and NE passes).
REQ-023 Reset deasserted mid-stream SHALL take effect with no partial flag update on the first following edge.

Configuration
REQ-024 With macro COND_SQUASH_COUNT_EN defined:
- SquashCount SHALL increment by 1 on each edge where StallE=0, CondExE=0 and (PCSE|RegWE|MemWE|FlagWE!=0).
- It SHALL saturate at 16'hFFFF.
- Without the macro, SquashCount SHALL be tied to 0 and no counter register SHALL be synthesised.

Structure
REQ-025 A shared package cond_pkg SHALL hold:
- the 4-bit condition-code constants (EQ..AL, NV);
- the flag bit index constants N=3, Z=2, C=1, V=0;
- the FlagWE bit index constants.
REQ-026 Condition evaluation SHALL live in one combinational sub-module cond_check (inputs CondE and Flags, output CondExE), instantiated once.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Reset, then CondE=0000 (EQ) with RegWE=1 -> CondExE=0, RegWriteE=0; CondE=0001 (NE) -> RegWriteE=1.
- CondE=1110 (AL), FlagWE=3'b111, ALUFlags=0100 -> next cycle Flags=0100; CondE=0000 -> CondExE=1.
- Flags=0100, CondE=0001, FlagWE=3'b111, ALUFlags=1000 -> Flags stay 0100; SquashCount increments by 1 (macro on).
- CondE=1110, FlagWE=3'b010, ALUFlags=1111 from Flags=0000 -> Flags=0010 only; then CondE=1000 (HI) -> CondExE=1.
- StallE=1 with AL, MemWE=1, FlagWE=3'b111 -> MemWriteE=0 and Flags unchanged; RESET pulse mid-stall -> Flags=0000 immediately.
- Macro on, SquashCount preloaded to 16'hFFFF by 65535 failed ops, one more failed op -> SquashCount stays 16'hFFFF; macro off -> SquashCount=0 throughout.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution unit: condition codes,
// flag bit positions and flag-write enable positions.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Flag register bit positions, {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagWE bit positions
    localparam int FWE_NZ = 2;
    localparam int FWE_C  = 1;
    localparam int FWE_V  = 0;

endpackage

// File: rtl/cond_exec_unit_cond_check.sv
// Purely combinational condition-code evaluation against the flag register.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] CondE,
    input  logic [3:0] Flags,
    output logic       CondExE
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Decode the condition code into a pass/fail decision
    always_comb begin
        CondExE = 1'b0;
        case (cond_e'(CondE))
            COND_EQ: CondExE = z;
            COND_NE: CondExE = !z;
            COND_CS: CondExE = c;
            COND_CC: CondExE = !c;
            COND_MI: CondExE = n;
            COND_PL: CondExE = !n;
            COND_VS: CondExE = v;
            COND_VC: CondExE = !v;
            COND_HI: CondExE = c & !z;
            COND_LS: CondExE = !c | z;
            COND_GE: CondExE = (n == v);
            COND_LT: CondExE = (n != v);
            COND_GT: CondExE = !z & (n == v);
            COND_LE: CondExE = z | (n != v);
            COND_AL: CondExE = 1'b1;
            default: CondExE = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: gates execute-stage write controls by the
// condition check and owns the architectural {N,Z,C,V} flag register.
// Optional macro COND_SQUASH_COUNT_EN adds a saturating 16-bit counter of
// condition-failed instructions; without it SquashCount is tied to zero.
module cond_exec_unit
    import cond_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        StallE,
    input  logic [3:0]  CondE,
    input  logic [2:0]  FlagWE,
    input  logic        PCSE,
    input  logic        RegWE,
    input  logic        MemWE,
    input  logic        NoWriteE,
    input  logic [3:0]  ALUFlags,
    output logic        PCSrcE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        CondExE,
    output logic [3:0]  Flags,
    output logic [15:0] SquashCount
);

    logic [3:0] flags_q;
    logic       cond_ex;
    logic       advance;

    cond_check u_cond_check (
        .CondE   (CondE),
        .Flags   (flags_q),
        .CondExE (cond_ex)
    );

    assign advance   = cond_ex & !StallE;
    assign CondExE   = cond_ex;
    assign PCSrcE    = PCSE  & advance;
    assign MemWriteE = MemWE & advance;
    assign RegWriteE = RegWE & advance & !NoWriteE;
    assign Flags     = flags_q;

    // Flag register: per-group load on a passed, unstalled instruction
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags_q <= '0;
        end else if (advance) begin
            if (FlagWE[FWE_NZ]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagWE[FWE_C]) flags_q[FLAG_C] <= ALUFlags[FLAG_C];
            if (FlagWE[FWE_V]) flags_q[FLAG_V] <= ALUFlags[FLAG_V];
        end
    end

`ifdef COND_SQUASH_COUNT_EN
    logic [15:0] squash_q;
    logic        squash_evt;

    assign squash_evt  = !StallE & !cond_ex & (PCSE | RegWE | MemWE | (|FlagWE));
    assign SquashCount = squash_q;

    // Saturating count of instructions that did real work but failed their condition
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            squash_q <= '0;
        end else if (squash_evt && (squash_q != '1)) begin
            squash_q <= squash_q + 16'd1;
        end
    end
`else
    assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_cond_exec_unit.sv
module tb_cond_exec_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        StallE;
    logic [3:0]  CondE;
    logic [2:0]  FlagWE;
    logic        PCSE, RegWE, MemWE, NoWriteE;
    logic [3:0]  ALUFlags;
    logic        PCSrcE, RegWriteE, MemWriteE, CondExE;
    logic [3:0]  Flags;
    logic [15:0] SquashCount;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [15:0] exp_sq = '0;

`ifdef COND_SQUASH_COUNT_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    always #5 CLK = ~CLK;

    cond_exec_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .StallE      (StallE),
        .CondE       (CondE),
        .FlagWE      (FlagWE),
        .PCSE        (PCSE),
        .RegWE       (RegWE),
        .MemWE       (MemWE),
        .NoWriteE    (NoWriteE),
        .ALUFlags    (ALUFlags),
        .PCSrcE      (PCSrcE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .CondExE     (CondExE),
        .Flags       (Flags),
        .SquashCount (SquashCount)
    );

    task automatic idle();
        StallE = 0; CondE = 4'b0000; FlagWE = 3'b000;
        PCSE = 0; RegWE = 0; MemWE = 0; NoWriteE = 0; ALUFlags = 4'b0000;
    endtask

    // Record one failed-condition op that does work in the bench's own counter model
    task automatic note_squash();
        if (SQ_EN && exp_sq != 16'hFFFF) exp_sq = exp_sq + 16'd1;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        idle();
        RESET = 1;
        #1;
        total++; if (Flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", Flags); else passed++;
        total++; if (SquashCount !== 16'h0000) $display("FAIL reset_squash: got %h want 0000", SquashCount); else passed++;
        CondE = 4'b0000; RegWE = 1; #1;
        total++; if (CondExE !== 1'b0) $display("FAIL reset_eq_condex: got %b want 0", CondExE); else passed++;
        total++; if (RegWriteE !== 1'b0) $display("FAIL reset_eq_regwrite: got %b want 0", RegWriteE); else passed++;
        CondE = 4'b0001; #1;
        total++; if (RegWriteE !== 1'b1) $display("FAIL reset_ne_regwrite: got %b want 1", RegWriteE); else passed++;
        tick();
        total++; if (Flags !== 4'b0000) $display("FAIL reset_held_flags: got %b want 0000", Flags); else passed++;
        @(negedge CLK); RESET = 0; idle(); exp_sq = '0;
    endtask

    task automatic test_gating();
        @(negedge CLK);
        CondE = 4'b0001; PCSE = 1; RegWE = 1; MemWE = 1; NoWriteE = 1; #1;
        total++; if (PCSrcE !== 1'b1) $display("FAIL gate_pcsrc: got %b want 1", PCSrcE); else passed++;
        total++; if (MemWriteE !== 1'b1) $display("FAIL gate_memwrite: got %b want 1", MemWriteE); else passed++;
        total++; if (RegWriteE !== 1'b0) $display("FAIL gate_nowrite: got %b want 0", RegWriteE); else passed++;
        NoWriteE = 0; #1;
        total++; if (RegWriteE !== 1'b1) $display("FAIL gate_regwrite: got %b want 1", RegWriteE); else passed++;
        CondE = 4'b0000; #1;
        total++; if ({PCSrcE, RegWriteE, MemWriteE} !== 3'b000) $display("FAIL gate_eq_fail: got %b want 000", {PCSrcE, RegWriteE, MemWriteE}); else passed++;
        CondE = 4'b0001;
        tick(); idle();
    endtask

    task automatic test_flag_update();
        @(negedge CLK);
        CondE = 4'b1110; FlagWE = 3'b111; ALUFlags = 4'b0100; #1;
        total++; if (Flags !== 4'b0000) $display("FAIL flag_no_bypass: got %b want 0000", Flags); else passed++;
        tick();
        total++; if (Flags !== 4'b0100) $display("FAIL flag_load_all: got %b want 0100", Flags); else passed++;
        @(negedge CLK); idle(); CondE = 4'b0000; #1;
        total++; if (CondExE !== 1'b1) $display("FAIL flag_eq_pass: got %b want 1", CondExE); else passed++;
    endtask

    task automatic test_cond_fail_hold();
        @(negedge CLK);
        CondE = 4'b0001; FlagWE = 3'b111; ALUFlags = 4'b1000; #1;
        total++; if (CondExE !== 1'b0) $display("FAIL fail_condex: got %b want 0", CondExE); else passed++;
        tick(); note_squash();
        total++; if (Flags !== 4'b0100) $display("FAIL fail_flags_hold: got %b want 0100", Flags); else passed++;
        total++; if (SquashCount !== exp_sq) $display("FAIL fail_squash_inc: got %h want %h", SquashCount, exp_sq); else passed++;
        @(negedge CLK); idle();
    endtask

    task automatic test_partial_flags();
        @(negedge CLK); RESET = 1; #1; RESET = 0; exp_sq = '0;
        total++; if (Flags !== 4'b0000) $display("FAIL partial_reset: got %b want 0000", Flags); else passed++;
        CondE = 4'b1110; FlagWE = 3'b010; ALUFlags = 4'b1111;
        tick();
        total++; if (Flags !== 4'b0010) $display("FAIL partial_c_only: got %b want 0010", Flags); else passed++;
        @(negedge CLK); idle(); CondE = 4'b1000; #1;
        total++; if (CondExE !== 1'b1) $display("FAIL partial_hi: got %b want 1", CondExE); else passed++;
        CondE = 4'b1001; #1;
        total++; if (CondExE !== 1'b0) $display("FAIL partial_ls: got %b want 0", CondExE); else passed++;
        CondE = 4'b1110; FlagWE = 3'b001; ALUFlags = 4'b0001;
        tick();
        total++; if (Flags !== 4'b0011) $display("FAIL partial_v_only: got %b want 0011", Flags); else passed++;
        @(negedge CLK); idle(); CondE = 4'b1010; #1;
        total++; if (CondExE !== 1'b0) $display("FAIL partial_ge: got %b want 0", CondExE); else passed++;
        CondE = 4'b1011; #1;
        total++; if (CondExE !== 1'b1) $display("FAIL partial_lt: got %b want 1", CondExE); else passed++;
        // one failed op so the stall test has a nonzero count to hold
        CondE = 4'b1111; PCSE = 1;
        tick(); note_squash();
        total++; if (SquashCount !== exp_sq) $display("FAIL partial_squash: got %h want %h", SquashCount, exp_sq); else passed++;
        @(negedge CLK); idle();
    endtask

    task automatic test_stall_reset();
        @(negedge CLK);
        StallE = 1; CondE = 4'b1110; MemWE = 1; RegWE = 1; PCSE = 1;
        FlagWE = 3'b111; ALUFlags = 4'b1100; #1;
        total++; if ({PCSrcE, RegWriteE, MemWriteE} !== 3'b000) $display("FAIL stall_gated: got %b want 000", {PCSrcE, RegWriteE, MemWriteE}); else passed++;
        total++; if (CondExE !== 1'b1) $display("FAIL stall_condex: got %b want 1", CondExE); else passed++;
        tick();
        total++; if (Flags !== 4'b0011) $display("FAIL stall_flags_hold: got %b want 0011", Flags); else passed++;
        @(negedge CLK); CondE = 4'b1111;
        tick();
        total++; if (SquashCount !== exp_sq) $display("FAIL stall_squash_hold: got %h want %h", SquashCount, exp_sq); else passed++;
        #2; RESET = 1; #1;
        total++; if (Flags !== 4'b0000) $display("FAIL stall_reset_flags: got %b want 0000", Flags); else passed++;
        total++; if (SquashCount !== 16'h0000) $display("FAIL stall_reset_squash: got %h want 0000", SquashCount); else passed++;
        @(negedge CLK); RESET = 0; exp_sq = '0;
        // first edge after reset release must not apply the stalled update
        tick();
        total++; if (Flags !== 4'b0000) $display("FAIL post_reset_flags: got %b want 0000", Flags); else passed++;
        @(negedge CLK); idle();
    endtask

    task automatic test_cond_table();
        logic [15:0] tab;
        @(negedge CLK); CondE = 4'b1110; FlagWE = 3'b111; ALUFlags = 4'b1010;
        tick(); @(negedge CLK); idle();
        tab = 16'h6996;
        for (int i = 0; i < 16; i++) begin
            CondE = 4'(i); #1;
            total++; if (CondExE !== tab[i]) $display("FAIL table_1010_cond%0d: got %b want %b", i, CondExE, tab[i]); else passed++;
        end
        @(negedge CLK); CondE = 4'b1110; FlagWE = 3'b111; ALUFlags = 4'b0101;
        tick(); @(negedge CLK); idle();
        tab = 16'h6A69;
        for (int i = 0; i < 16; i++) begin
            CondE = 4'(i); #1;
            total++; if (CondExE !== tab[i]) $display("FAIL table_0101_cond%0d: got %b want %b", i, CondExE, tab[i]); else passed++;
        end
    endtask

    task automatic test_bubble();
        @(negedge CLK); idle();
        repeat (3) tick();
        total++; if (Flags !== 4'b0101) $display("FAIL bubble_flags: got %b want 0101", Flags); else passed++;
        total++; if (SquashCount !== exp_sq) $display("FAIL bubble_squash: got %h want %h", SquashCount, exp_sq); else passed++;
    endtask

    task automatic test_saturation();
        @(negedge CLK); RESET = 1; #1; RESET = 0; exp_sq = '0;
        idle(); CondE = 4'b1111; PCSE = 1;
        if (SQ_EN) begin
            repeat (65534) @(posedge CLK);
            #1;
            total++; if (SquashCount !== 16'hFFFE) $display("FAIL sat_fffe: got %h want fffe", SquashCount); else passed++;
            tick();
            total++; if (SquashCount !== 16'hFFFF) $display("FAIL sat_ffff: got %h want ffff", SquashCount); else passed++;
            tick();
            total++; if (SquashCount !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", SquashCount); else passed++;
        end else begin
            repeat (20) tick();
            total++; if (SquashCount !== 16'h0000) $display("FAIL sat_disabled: got %h want 0000", SquashCount); else passed++;
        end
        @(negedge CLK); idle();
    endtask

    initial begin
        test_reset();
        test_gating();
        test_flag_update();
        test_cond_fail_hold();
        test_partial_flags();
        test_stall_reset();
        test_cond_table();
        test_bubble();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
